// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
// Redirect classes are encoded in priority order so they compare as unsigned values.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        ERET = 2'd2,
        EXC  = 2'd3
    } rclass_e;

    // Widest address the alignment helper handles; callers zero-extend and truncate.
    localparam int unsigned ADDR_MAX = 64;

    function automatic logic [ADDR_MAX-1:0] align_target(
        input logic [ADDR_MAX-1:0] addr,
        input int unsigned         inst_bytes
    );
        logic [ADDR_MAX-1:0] mask;
        mask = ADDR_MAX'(inst_bytes) - ADDR_MAX'(1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect register: holds one target and its class while fetch is stalled.
// A new redirect overwrites only when its class is at least as urgent as the stored one.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  rclass_e         i_class,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_clear,
    output logic            o_written,
    output logic            o_valid,
    output rclass_e         o_class,
    output logic [XLEN-1:0] o_target
);

    rclass_e         r_class;
    logic [XLEN-1:0] r_target;
    logic            w_write;

    // An empty buffer holds NONE, so any real redirect satisfies the compare.
    assign w_write = i_load && (i_class != NONE) && (i_class >= r_class);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_class  <= NONE;
            r_target <= '0;
        end else if (i_clear) begin
            r_class  <= NONE;
        end else if (w_write) begin
            r_class  <= i_class;
            r_target <= i_target;
        end
    end

    assign o_written = w_write;
    assign o_valid   = (r_class != NONE);
    assign o_class   = r_class;
    assign o_target  = r_target;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: boot, sequential increment, stall hold, prioritised
// redirects (buffered under stall), halt/wake, and a valid/ready fetch handshake.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            if_ready,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [XLEN-1:0] epc_in,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            align_err
);

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_align_err;
    logic            w_align_next;

    rclass_e         w_live_class;
    logic [XLEN-1:0] w_live_raw;
    logic [XLEN-1:0] w_live_target;
    logic            w_live_mis;

    logic            w_in_run;
    logic            w_hold;
    logic            w_buf_load;
    logic            w_buf_clear;
    logic            w_buf_written;
    logic            w_pend_valid;
    rclass_e         w_pend_class;
    logic [XLEN-1:0] w_pend_target;

    assign pc_plus = r_pc + XLEN'(INST_BYTES);

    // Fixed priority: exception over eret over branch.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        w_live_class = NONE;
        w_live_raw   = r_pc;
        if (exc_req) begin
            w_live_class = EXC;
            w_live_raw   = EXC_VECTOR;
        end else if (eret_req) begin
            w_live_class = ERET;
            w_live_raw   = epc_in;
        end else if (br_taken) begin
            w_live_class = BR;
            w_live_raw   = br_target;
        end
    end

    assign w_live_target = XLEN'(align_target(ADDR_MAX'(w_live_raw), INST_BYTES));
    assign w_live_mis    = (w_live_target != w_live_raw);

    assign w_in_run    = (r_state == RUN);
    assign w_hold      = stall || halt;
    assign w_buf_load  = w_in_run && w_hold;
    assign w_buf_clear = (w_in_run && !w_hold && (w_live_class == NONE) && w_pend_valid)
                      || ((r_state == HALTED) && exc_req);

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_buf_load),
        .i_class   (w_live_class),
        .i_target  (w_live_target),
        .i_clear   (w_buf_clear),
        .o_written (w_buf_written),
        .o_valid   (w_pend_valid),
        .o_class   (w_pend_class),
        .o_target  (w_pend_target)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else        r_state <= w_state_next;
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (halt && !stall) w_state_next = HALTED;
            HALTED:  if (exc_req) w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    // FSM outputs
    always_comb begin
        pc_valid         = (r_state == RUN);
        pc               = r_pc;
        redirect_pending = w_pend_valid;
        align_err        = r_align_err;
    end

    // Next-PC mux; a redirect while halting is only buffered, never loaded.
    always_comb begin
        w_pc_next    = r_pc;
        w_align_next = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_hold) begin
                    w_align_next = w_buf_written && w_live_mis;
                end else if (w_live_class != NONE) begin
                    w_pc_next    = w_live_target;
                    w_align_next = w_live_mis;
                end else if (w_pend_valid) begin
                    w_pc_next    = w_pend_target;
                end else if (if_ready) begin
                    w_pc_next    = pc_plus;
                end
            end
            HALTED: begin
                if (exc_req) begin
                    w_pc_next    = w_live_target;
                    w_align_next = w_live_mis;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_align_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_align_err <= w_align_next;
        end
    end

    // Class is carried through the buffer for the overwrite compare only.
    logic w_unused;
    assign w_unused = ^w_pend_class;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_pc_gen;

    localparam logic [31:0] EXC_VEC = 32'h0000_0080;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        if_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_in;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        pc_valid;
    logic        redirect_pending;
    logic        align_err;

    int checks;
    int failures;

    // Behavioural model state
    int          m_mode;
    logic [31:0] m_pc;
    int          m_pend_prio;
    logic [31:0] m_pend_tgt;
    logic        m_align;

    pc_gen #(
        .XLEN         (32),
        .INST_BYTES   (4),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (EXC_VEC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .if_ready         (if_ready),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc_in           (epc_in),
        .halt             (halt),
        .pc               (pc),
        .pc_plus          (pc_plus),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .align_err        (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic mdl_reset();
        m_mode      = M_BOOT;
        m_pc        = 32'h0;
        m_pend_prio = 0;
        m_pend_tgt  = 32'h0;
        m_align     = 1'b0;
    endtask

    // One clock of the model, computed from the input rules directly.
    task automatic mdl_step();
        int          prio;
        logic [31:0] raw;
        logic [31:0] tgt;
        logic        mis;
        logic        new_align;
        prio = 0;
        raw  = 32'h0;
        if (exc_req)       begin prio = 3; raw = EXC_VEC;   end
        else if (eret_req) begin prio = 2; raw = epc_in;    end
        else if (br_taken) begin prio = 1; raw = br_target; end
        tgt       = (raw / 4) * 4;
        mis       = (raw % 4) != 0;
        new_align = 1'b0;
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (stall || halt) begin
                if (prio > 0 && prio >= m_pend_prio) begin
                    m_pend_prio = prio;
                    m_pend_tgt  = tgt;
                    new_align   = mis;
                end
                if (!stall) m_mode = M_HALT;
            end else if (prio > 0) begin
                m_pc      = tgt;
                new_align = mis;
            end else if (m_pend_prio > 0) begin
                m_pc        = m_pend_tgt;
                m_pend_prio = 0;
            end else if (if_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (exc_req) begin
                m_pc        = tgt;
                new_align   = mis;
                m_mode      = M_RUN;
                m_pend_prio = 0;
            end
        end
        m_align = new_align;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stall     = 1'b0;
        if_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
        epc_in    = 32'h0;
        halt      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        mdl_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (pc !== 32'h0)           begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        if (pc_valid !== 1'b0)      begin failures++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", redirect_pending); end
        if (align_err !== 1'b0)     begin failures++; $display("FAIL reset_align: got %b expected 0", align_err); end
        if_ready = 1'b1;
        tick();
        checks += 2;
        if (pc !== 32'h0)      begin failures++; $display("FAIL boot_pc: got %h expected %h", pc, 32'h0); end
        if (pc_valid !== 1'b1) begin failures++; $display("FAIL boot_valid: got %b expected 1", pc_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [2];
        exp_seq[0] = 32'h4;
        exp_seq[1] = 32'h8;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== exp_seq[i]) begin failures++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_seq[i]); end
        end
        checks++;
        if (pc_plus !== 32'hC) begin failures++; $display("FAIL seq_pc_plus: got %h expected %h", pc_plus, 32'hC); end
    endtask

    task automatic test_if_ready();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'h8) begin failures++; $display("FAIL ready_hold[%0d]: got %h expected %h", i, pc, 32'h8); end
        end
        if_ready = 1'b1;
        tick();
        checks++;
        if (pc !== 32'hC) begin failures++; $display("FAIL ready_release: got %h expected %h", pc, 32'hC); end
        tick();
        checks++;
        if (pc !== 32'h10) begin failures++; $display("FAIL ready_step: got %h expected %h", pc, 32'h10); end
    endtask

    task automatic test_priority();
        br_taken = 1'b1; br_target = 32'h200;
        eret_req = 1'b1; epc_in    = 32'h300;
        exc_req  = 1'b1;
        tick();
        clear_inputs();
        if_ready = 1'b1;
        checks += 2;
        if (pc !== EXC_VEC)     begin failures++; $display("FAIL prio_pc: got %h expected %h", pc, EXC_VEC); end
        if (align_err !== 1'b0) begin failures++; $display("FAIL prio_align: got %b expected 0", align_err); end
        eret_req = 1'b1; epc_in = 32'h300; br_taken = 1'b1; br_target = 32'h200;
        tick();
        clear_inputs();
        if_ready = 1'b1;
        checks++;
        if (pc !== 32'h300) begin failures++; $display("FAIL prio_eret_pc: got %h expected %h", pc, 32'h300); end
    endtask

    task automatic test_stall_buffer();
        tick();
        checks++;
        if (pc !== 32'h304) begin failures++; $display("FAIL buf_pre_pc: got %h expected %h", pc, 32'h304); end
        // branch first, exception second: exception overwrites
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h400;
        tick();
        br_taken = 1'b0; exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        tick();
        checks += 2;
        if (pc !== 32'h304)            begin failures++; $display("FAIL buf_hold_pc: got %h expected %h", pc, 32'h304); end
        if (redirect_pending !== 1'b1) begin failures++; $display("FAIL buf_pending: got %b expected 1", redirect_pending); end
        stall = 1'b0;
        tick();
        checks += 2;
        if (pc !== EXC_VEC)            begin failures++; $display("FAIL buf_apply_pc: got %h expected %h", pc, EXC_VEC); end
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL buf_cleared: got %b expected 0", redirect_pending); end
        tick();
        // exception first, branch second: branch must not replace it
        stall = 1'b1; exc_req = 1'b1;
        tick();
        exc_req = 1'b0; br_taken = 1'b1; br_target = 32'h400;
        tick();
        br_taken = 1'b0; stall = 1'b0;
        tick();
        checks += 2;
        if (pc !== EXC_VEC)            begin failures++; $display("FAIL buf_keep_exc_pc: got %h expected %h", pc, EXC_VEC); end
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL buf_keep_exc_pending: got %b expected 0", redirect_pending); end
    endtask

    task automatic test_halt_misalign();
        br_taken = 1'b1; br_target = 32'h20;
        tick();
        br_taken = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        checks += 2;
        if (pc !== 32'h20)     begin failures++; $display("FAIL halt_pc: got %h expected %h", pc, 32'h20); end
        if (pc_valid !== 1'b0) begin failures++; $display("FAIL halt_valid: got %b expected 0", pc_valid); end
        br_taken = 1'b1; br_target = 32'h500;
        tick();
        br_taken = 1'b0;
        checks += 2;
        if (pc !== 32'h20)     begin failures++; $display("FAIL halt_ignore_br: got %h expected %h", pc, 32'h20); end
        if (pc_valid !== 1'b0) begin failures++; $display("FAIL halt_still_parked: got %b expected 0", pc_valid); end
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        checks += 2;
        if (pc !== EXC_VEC)    begin failures++; $display("FAIL wake_pc: got %h expected %h", pc, EXC_VEC); end
        if (pc_valid !== 1'b1) begin failures++; $display("FAIL wake_valid: got %b expected 1", pc_valid); end
        br_taken = 1'b1; br_target = 32'h1002;
        tick();
        br_taken = 1'b0;
        checks += 2;
        if (pc !== 32'h1000)    begin failures++; $display("FAIL misalign_pc: got %h expected %h", pc, 32'h1000); end
        if (align_err !== 1'b1) begin failures++; $display("FAIL misalign_pulse: got %b expected 1", align_err); end
        tick();
        checks += 2;
        if (pc !== 32'h1004)    begin failures++; $display("FAIL misalign_next_pc: got %h expected %h", pc, 32'h1004); end
        if (align_err !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle: got %b expected 0", align_err); end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        tick();
        br_taken = 1'b0;
        checks += 2;
        if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
        if (pc_plus !== 32'h0)    begin failures++; $display("FAIL wrap_pc_plus: got %h expected %h", pc_plus, 32'h0); end
        tick();
        checks += 2;
        if (pc !== 32'h0)       begin failures++; $display("FAIL wrap_next: got %h expected %h", pc, 32'h0); end
        if (align_err !== 1'b0) begin failures++; $display("FAIL wrap_align: got %b expected 0", align_err); end
    endtask

    task automatic test_async_reset();
        tick();
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h600;
        tick();
        checks += 2;
        if (redirect_pending !== 1'b1) begin failures++; $display("FAIL areset_pre_pending: got %b expected 1", redirect_pending); end
        if (pc !== 32'h4)              begin failures++; $display("FAIL areset_pre_pc: got %h expected %h", pc, 32'h4); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (pc !== 32'h0)              begin failures++; $display("FAIL areset_pc: got %h expected %h", pc, 32'h0); end
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL areset_pending: got %b expected 0", redirect_pending); end
        if (pc_valid !== 1'b0)         begin failures++; $display("FAIL areset_valid: got %b expected 0", pc_valid); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            stall    = ($urandom_range(0, 9) < 3);
            if_ready = ($urandom_range(0, 9) < 7);
            br_taken = ($urandom_range(0, 9) < 2);
            eret_req = ($urandom_range(0, 9) == 0);
            exc_req  = ($urandom_range(0, 19) == 0);
            halt     = ($urandom_range(0, 19) == 0);
            br_target = $urandom;
            epc_in    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                br_target[1:0] = 2'b00;
                epc_in[1:0]    = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) br_target = 32'hFFFF_FFF8;
            tick();
            checks += 5;
            if (pc !== m_pc) begin failures++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, pc, m_pc); end
            if (pc_plus !== m_pc + 32'd4) begin failures++; $display("FAIL rand_pc_plus[%0d]: got %h expected %h", i, pc_plus, m_pc + 32'd4); end
            if (pc_valid !== (m_mode == M_RUN)) begin failures++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, pc_valid, m_mode == M_RUN); end
            if (redirect_pending !== (m_pend_prio > 0)) begin failures++; $display("FAIL rand_pending[%0d]: got %b expected %b", i, redirect_pending, m_pend_prio > 0); end
            if (align_err !== m_align) begin failures++; $display("FAIL rand_align[%0d]: got %b expected %b", i, align_err, m_align); end
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_inputs();
        mdl_reset();
        test_reset();
        test_sequential();
        test_if_ready();
        test_priority();
        test_stall_buffer();
        test_halt_misalign();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
